fifo_dc_wr_ctrl: RTL and testbench
==================================

Name: fifo_dc_wr_ctrl

Overview:
Write-side controller of the dual-clock FIFO, running entirely in the wclk domain.
- Accepts push requests from the producer and drives write enable, address and data into the dual-port RAM write port.
- Maintains the binary and Gray write pointers.
- Synchronises the read-domain Gray pointer into wclk and generates full, almost_full and fill-level status.

Parameters:
ADDR_WIDTH, 8, RAM address width; FIFO depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, data word width
AFULL_THRESH, 2**ADDR_WIDTH-2, fill level at or above which almost_full asserts

Ports:
wclk  input  1  write clock
wrst  input  1  reset, asynchronous, active-high
wr_en  input  1  push request from producer
wr_data  input  DATA_WIDTH  push data
full  output  1  FIFO full, registered
almost_full  output  1  fill level >= AFULL_THRESH, registered
wr_count  output  ADDR_WIDTH+1  fill level as seen from the write domain, registered
ram_we  output  1  RAM write enable
ram_waddr  output  ADDR_WIDTH  RAM write address
ram_di  output  DATA_WIDTH  RAM write data
wptr_gray  output  ADDR_WIDTH+1  Gray write pointer, registered, consumed by the read domain
rptr_gray_async  input  ADDR_WIDTH+1  Gray read pointer from the rclk domain, unsynchronised
overflow  output  1  sticky overflow flag; meaningful only with WR_OVERFLOW_FLAG_EN

Behaviour:
- Reset (wrst high, asynchronous) clears: wbin, wptr_gray, both sync stages, full, almost_full, wr_count and overflow, all to 0.
- While wrst is high, ram_we is forced to 0.
- Push acceptance: push = wr_en & ~full.
  - ram_we = push, combinational.
  - ram_waddr = wbin[ADDR_WIDTH-1:0].
  - ram_di = wr_data, pass-through.
  - The data is written into the RAM on the same wclk edge that the push is accepted.
- Pointer update: wbin_next = wbin + push, wrapping modulo 2**(ADDR_WIDTH+1). wgray_next = wbin_next ^ (wbin_next >> 1). Both are registered on each wclk edge.
- Synchronisation: rptr_gray_async passes through a 2-flop synchroniser into rsync2. rbin_sync = Gray-to-binary of rsync2.
- full register: full <= (wgray_next == {~rsync2[AW:AW-1], rsync2[AW-2:0]}).
  - full asserts on the same edge as the push that fills the FIFO. No write beyond depth is ever issued.
  - full deasserts no later than the 3rd wclk edge after rptr_gray_async changes (2 synchroniser edges + 1 register edge).
- wr_count <= wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1). Range is 0..2**ADDR_WIDTH.
- almost_full <= (wbin_next - rbin_sync) >= AFULL_THRESH.
- Status is pessimistic: wr_count may overstate the true level during synchroniser lag, but never understates it.
- Wrap-around: the MSB of the pointer distinguishes full from empty when the address bits are equal. Pushes continue correctly across the 2**(ADDR_WIDTH+1) boundary.
- wr_en while full: ignored. No RAM write, pointer unchanged.
- Simultaneous push and read-pointer change: both take effect. full/wr_count reflect the new push plus the synchronised read pointer, in that order.
- Reset mid-operation: pointers return to 0 immediately. The read domain must be reset concurrently; the RAM contents are don't-care.

Optional Feature:
WR_OVERFLOW_FLAG_EN
- Defined: overflow is set on any wclk edge where wr_en & full. It stays set until wrst. An extra 16-bit drop counter (internal, not on ports) increments on each dropped push and saturates at 16'hFFFF.
- Undefined: overflow is tied to 0 and no counter logic is built.

Test Plan:
- Reset with wrst=1 mid-clock -> all outputs 0 immediately, ram_we=0; after release, first push writes addr 0.
- ADDR_WIDTH=3, rptr held at 0, 8 pushes 0x11..0x18 -> addresses 0..7 written; full=1 on the 8th edge; wr_count=8; almost_full=1 from the 6th push (AFULL_THRESH=6).
- FIFO full, wr_en held 3 cycles -> no ram_we; wptr_gray unchanged; overflow=1 with the macro, 0 without.
- FIFO full, rptr_gray_async stepped from 0000 to 0001 -> full=0 within 3 wclk edges; wr_count=7.
- 20 push/read cycles with read trailing by 2 -> pointer wraps past 1111 to 0000; full never asserts; wr_count stays <= 2 plus sync lag; data order preserved at RAM addresses.
- Push on the same edge rptr advances, at level 7 -> wr_count stays 7 after sync settles; full=0.

Source files
------------

// File: rtl/fifo_dc_wr_ctrl.sv
// fifo_dc_wr_ctrl -- write-side controller of the dual-clock FIFO (wclk domain).
//
// Accepts producer pushes, drives the RAM write port, keeps the binary and
// Gray write pointers, synchronises the read-domain Gray pointer and derives
// registered full / almost_full / fill-level status from it.
//
// Optional build macro: WR_OVERFLOW_FLAG_EN
//   defined   -> sticky overflow flag plus an internal saturating 16-bit drop counter
//   undefined -> overflow tied to 0, no extra logic
//
// Ports:
//   wclk, wrst          write clock, asynchronous active-high reset
//   wr_en, wr_data      push request and push data from the producer
//   full, almost_full   registered status flags
//   wr_count            registered fill level as seen from the write domain
//   ram_we/waddr/di     dual-port RAM write port
//   wptr_gray           registered Gray write pointer for the read domain
//   rptr_gray_async     Gray read pointer from the rclk domain (unsynchronised)
//   overflow            sticky dropped-push flag (optional feature)

module fifo_dc_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  overflow
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] rsync1_q, rsync2_q;
    logic [AW:0] rbin_sync;
    logic [AW:0] level_d;
    logic [AW:0] full_gray;
    logic        full_q, afull_q;
    logic [AW:0] wcount_q;
    logic        push;

    always_comb begin
        push      = wr_en & ~full_q;
        wbin_d    = wbin_q + (AW+1)'(push);
        wgray_d   = wbin_d ^ (wbin_d >> 1);
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        rbin_sync = '0;
        for (int unsigned i = 0; i <= AW; i++) begin
            rbin_sync[i] = ^(rsync2_q >> i);
        end
        level_d   = wbin_d - rbin_sync;
        // Write pointer one full lap ahead of the read pointer, in Gray form.
        full_gray = {~rsync2_q[AW:AW-1], rsync2_q[AW-2:0]};
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            rsync1_q <= '0;
            rsync2_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wcount_q <= '0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            rsync1_q <= rptr_gray_async;
            rsync2_q <= rsync1_q;
            full_q   <= (wgray_d == full_gray);
            wcount_q <= level_d;
            afull_q  <= (level_d >= AFULL_LVL);
        end
    end

    assign ram_we      = push & ~wrst;
    assign ram_waddr   = wbin_q[AW-1:0];
    assign ram_di      = wr_data;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_count    = wcount_q;
    assign wptr_gray   = wgray_q;

`ifdef WR_OVERFLOW_FLAG_EN
    logic        overflow_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (wr_en && full_q) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_dc_wr_ctrl.sv
// Directed testbench for fifo_dc_wr_ctrl with ADDR_WIDTH=3 (depth 8), AFULL_THRESH=6.
// Inputs are driven 1 time unit after the rising wclk edge; outputs are sampled there too.

module tb_fifo_dc_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_count;
    logic       ram_we;
    logic [2:0] ram_waddr;
    logic [7:0] ram_di;
    logic [3:0] wptr_gray;
    logic [3:0] rptr_gray_async;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    fifo_dc_wr_ctrl #(
        .ADDR_WIDTH  (3),
        .DATA_WIDTH  (8),
        .AFULL_THRESH(6)
    ) dut (
        .wclk           (wclk),
        .wrst           (wrst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .almost_full    (almost_full),
        .wr_count       (wr_count),
        .ram_we         (ram_we),
        .ram_waddr      (ram_waddr),
        .ram_di         (ram_di),
        .wptr_gray      (wptr_gray),
        .rptr_gray_async(rptr_gray_async),
        .overflow       (overflow)
    );

    always #5 wclk = ~wclk;

`ifdef WR_OVERFLOW_FLAG_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray code of write pointer after 1..8 pushes from zero
    logic [3:0] gray_tab [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    logic [3:0] rb;
    logic [3:0] wb;
    int         exp_cnt;

    initial begin
        wrst = 1'b1; wr_en = 1'b0; wr_data = '0; rptr_gray_async = '0;
        tick(); tick();
        chk("rst_full",  full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_count", wr_count, 0);
        chk("rst_wptr",  wptr_gray, 0);
        chk("rst_we",    ram_we, 0);
        chk("rst_ovf",   overflow, 0);
        wrst = 1'b0;

        // Two pushes, then asynchronous reset in mid-cycle with wr_en still high
        wr_en = 1'b1; wr_data = 8'hA1; tick();
        wr_data = 8'hA2; tick();
        chk("pre_rst_count", wr_count, 2);
        chk("pre_rst_wptr",  wptr_gray, 4'b0011);
        #2 wrst = 1'b1;
        #1;
        chk("async_rst_wptr",  wptr_gray, 0);
        chk("async_rst_count", wr_count, 0);
        chk("async_rst_we",    ram_we, 0);
        chk("async_rst_full",  full, 0);
        tick();
        wr_en = 1'b0; wrst = 1'b0;

        // Fill 8 entries with read pointer at 0
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h11 + 8'(i);
            #1;
            chk("fill_we",   ram_we, 1);
            chk("fill_addr", ram_waddr, 32'(i));
            chk("fill_di",   ram_di, 32'(8'h11 + i));
            tick();
            chk("fill_count", wr_count, 32'(i + 1));
            chk("fill_full",  full, (i == 7) ? 1 : 0);
            chk("fill_afull", almost_full, (i >= 5) ? 1 : 0);
            chk("fill_wptr",  wptr_gray, gray_tab[i]);
        end

        // Pushes while full are dropped
        wr_data = 8'h55;
        for (int j = 0; j < 3; j++) begin
            wr_en = 1'b1;
            #1;
            chk("ovf_we", ram_we, 0);
            tick();
            chk("ovf_wptr",  wptr_gray, 4'b1100);
            chk("ovf_count", wr_count, 8);
            chk("ovf_full",  full, 1);
            chk("ovf_flag",  overflow, EXP_OVF);
        end
        wr_en = 1'b0;

        // One read: full clears on the 3rd edge
        rptr_gray_async = 4'b0001;
        tick(); tick();
        chk("rd_full_lag", full, 1);
        tick();
        chk("rd_full",  full, 0);
        chk("rd_count", wr_count, 7);
        chk("rd_afull", almost_full, 1);

        // Push on the same edge the read pointer advances, at level 7
        wr_en = 1'b1; wr_data = 8'h19; rptr_gray_async = 4'b0011;
        #1;
        chk("simul_we",   ram_we, 1);
        chk("simul_addr", ram_waddr, 0);
        tick();
        wr_en = 1'b0;
        chk("simul_count_lag", wr_count, 8);
        chk("simul_full_lag",  full, 1);
        tick(); tick();
        chk("simul_count", wr_count, 7);
        chk("simul_full",  full, 0);

        // Drain completely (write binary pointer is 9)
        rptr_gray_async = 4'b1101;
        tick(); tick(); tick();
        chk("drain_count", wr_count, 0);
        chk("drain_full",  full, 0);
        chk("drain_afull", almost_full, 0);

        // 20 pushes with reads trailing; pointer wraps past 1111
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(k);
            rb = 4'(9 + ((k > 0) ? k - 1 : 0));
            rptr_gray_async = g(rb);
            wb = 4'(9 + k);
            #1;
            chk("wrap_addr", ram_waddr, 32'(wb[2:0]));
            chk("wrap_di",   ram_di, 32'(8'h30 + k));
            tick();
            exp_cnt = (k < 3) ? k + 1 : 4;
            chk("wrap_count", wr_count, 32'(exp_cnt));
            chk("wrap_full",  full, 0);
        end
        wr_en = 1'b0;
        chk("wrap_wptr", wptr_gray, 4'b1011);
        chk("end_ovf",   overflow, EXP_OVF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
